pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
- Parametrised N-channel successor to the single-output DE0 pulse generator.
- Each channel has its own programmable delay, high width, period, burst count and polarity.
- Channels start from a shared trigger input, per-channel soft triggers, or both.
- Sits under the board top level: config is written from a host/register bridge, and `pulse_out` is driven to GPIO_0/GPIO_1 pins.

Parameters:
- N_CH, 4, number of independent channels (1..16).
- CNT_W, 24, width of the delay/width/period counters in clk cycles.
- BURST_W, 16, width of the burst counter; burst value 0 means run continuously.
- CH_W, 4, width of the channel select field; must satisfy 2**CH_W >= N_CH.

Ports:
- clk  in  1  system clock, 50 MHz CLOCK_50 domain.
- rst_n  in  1  asynchronous active-low reset, synchronously deasserted upstream.
- cfg_wr  in  1  single-cycle config write strobe.
- cfg_ch  in  CH_W  channel select for the write.
- cfg_addr  in  3  register select: 0 delay, 1 width, 2 period, 3 burst, 4 ctrl (bit0 polarity, bit1 ext_trig_en).
- cfg_data  in  CNT_W  write data; burst uses [BURST_W-1:0], ctrl uses [1:0].
- ext_trig  in  1  shared external trigger; rising edge is active.
- sw_trig  in  N_CH  per-channel soft trigger; level sampled each cycle.
- stop  in  N_CH  per-channel abort; level sampled each cycle.
- pulse_out  out  N_CH  pulse outputs, registered.
- busy  out  N_CH  channel is in any state other than IDLE.
- done  out  N_CH  one-cycle strobe when a finite burst completes.

Behaviour:
- Reset, with rst_n low:
  - All channels go to IDLE; busy=0, done=0.
  - Config registers reset to delay=0, width=1, period=2, burst=1, ctrl=0.
  - `pulse_out` drives the idle level, which is 0 because polarity resets to 0.
- Config writes:
  - A write to a channel index >= N_CH or to cfg_addr > 4 is ignored.
  - Writes update the live config registers at any time.
- Starting a channel:
  - Start event = sw_trig[i] OR (ext_trig_en AND ext_trig rising edge). The edge is detected with a 1-cycle registered history.
  - A start is accepted only in IDLE; starts while busy are ignored.
  - On an accepted start, live config is copied into shadow registers. A running burst always uses the shadow values.
- Config clamps, applied at shadow load:
  - period < 2 is taken as 2.
  - width >= period is taken as period-1.
  - width = 0 gives periods with no high phase: the output stays at the idle level, but periods and the burst are still counted.
- Per-channel FSM states: IDLE, DELAY, HIGH, LOW.
  - IDLE -> DELAY on start if delay > 0, otherwise IDLE -> HIGH.
  - DELAY -> HIGH after delay cycles.
  - HIGH lasts width cycles, then goes to LOW.
  - LOW lasts period-width cycles. At the end of LOW: decrement remaining burst; if the remaining count reaches 0 (finite mode), go to IDLE and pulse done for one cycle; otherwise go to HIGH.
  - Continuous mode (burst=0) loops HIGH/LOW until stop is asserted.
- Latency:
  - Start sampled at edge k gives pulse_out active from edge k+1+delay.
  - Pulse period is exactly `period` cycles; active width is exactly `width` cycles.
- Output polarity: pulse_out = (state==HIGH) XOR polarity, registered. Polarity is taken from the shadow value while busy and from the live value while IDLE.
- stop[i]:
  - Forces IDLE at the next edge from any state; pulse_out returns to the idle level one cycle later.
  - done is not asserted on an abort.
  - If stop and start occur in the same cycle, stop wins.
- Channel independence: channels never share counters; a simultaneous ext_trig starts every enabled IDLE channel in the same cycle.
- Counters: no counter wraps. Each counter is loaded with its value-1 and counts down to 0. The burst counter is BURST_W bits, so max burst = 2**BURST_W-1.
- Async reset mid-burst aborts immediately; no done is generated.

Optional Feature:
- Macro: PULSE_GEN_TRIG_SYNC_EN.
- Defined: ext_trig passes through a 2-flop synchronizer before edge detection, adding exactly 2 cycles to start latency for ext_trig only. sw_trig latency is unchanged.
- Undefined: ext_trig is used directly. It must already be synchronous to clk.

Test Plan:
- Ch0 delay=3, width=2, period=5, burst=3, sw_trig[0] pulse at edge k -> pulse_out[0] high at k+4..k+5, k+9..k+10, k+14..k+15; done[0] at k+19; busy[0] low after that.
- Ch1 burst=0, width=1, period=4, ext_trig_en=1, ext_trig rise -> continuous 1-in-4 pulses; stop[1] asserted -> busy low next edge, pulse_out[1] low the following edge, no done.
- Ch2 width=10, period=4 -> clamped to width 3, period 4; ch2 polarity=1 -> idle output 1, active phase 0.
- Ch3 config rewritten to period=20 mid-burst -> the current burst keeps the old period; the next sw_trig uses 20.
- ext_trig with ch0/ch2 enabled and ch1 disabled -> ch0 and ch2 go busy on the same edge, ch1 stays idle; a retrigger while busy is ignored.
- rst_n low mid-burst -> all outputs at reset values asynchronously; config back to defaults. With PULSE_GEN_TRIG_SYNC_EN defined, the ext_trig latency test is +2 cycles.

Source files
------------

// File: rtl/pulse_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_multi
//  Purpose  : N-channel programmable pulse/burst generator with per-channel
//             delay, width, period, burst count and polarity.
//             Define PULSE_GEN_TRIG_SYNC_EN to pass ext_trig through a
//             2-flop synchronizer before edge detection.
//  Revision : 1.0  initial release
// ============================================================================
module pulse_gen_multi #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 24,
    parameter int BURST_W = 16,
    parameter int CH_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [2:0]         cfg_addr,
    input  logic [CNT_W-1:0]   cfg_data,
    input  logic               ext_trig,
    input  logic [N_CH-1:0]    sw_trig,
    input  logic [N_CH-1:0]    stop,
    output logic [N_CH-1:0]    pulse_out,
    output logic [N_CH-1:0]    busy,
    output logic [N_CH-1:0]    done
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_delay = 2'd1;
    localparam logic [1:0] c_st_high  = 2'd2;
    localparam logic [1:0] c_st_low   = 2'd3;

    logic w_ext_src;
    logic w_ext_rise;
    logic r_ext_prev;

`ifdef PULSE_GEN_TRIG_SYNC_EN
    logic r_ext_s1;
    logic r_ext_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_s1 <= 1'b0;
            r_ext_s2 <= 1'b0;
        end else begin
            r_ext_s1 <= ext_trig;
            r_ext_s2 <= r_ext_s1;
        end
    end

    assign w_ext_src = r_ext_s2;
`else
    assign w_ext_src = ext_trig;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_prev <= 1'b0;
        end else begin
            r_ext_prev <= w_ext_src;
        end
    end

    assign w_ext_rise = w_ext_src & ~r_ext_prev;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0]   r_delay;
        logic [CNT_W-1:0]   r_width;
        logic [CNT_W-1:0]   r_period;
        logic [BURST_W-1:0] r_burst;
        logic               r_pol;
        logic               r_ext_en;

        logic [CNT_W-1:0]   r_sh_width;
        logic [CNT_W-1:0]   r_sh_low;
        logic               r_sh_pol;
        logic               r_sh_cont;

        logic [1:0]         r_state;
        logic [1:0]         w_state_nxt;
        logic [CNT_W-1:0]   r_cnt;
        logic [CNT_W-1:0]   w_cnt_nxt;
        logic [BURST_W-1:0] r_rem;
        logic [BURST_W-1:0] w_rem_nxt;
        logic               w_load;
        logic               w_finish;
        logic               w_start;
        logic               w_sel;
        logic               w_pol;
        logic [CNT_W-1:0]   w_per_eff;
        logic [CNT_W-1:0]   w_wid_eff;
        logic [CNT_W-1:0]   w_low_eff;

        logic               r_pulse;
        logic               r_done_pend;
        logic               r_done;

        assign w_sel = cfg_wr && (cfg_ch == CH_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_delay  <= '0;
                r_width  <= CNT_W'(1);
                r_period <= CNT_W'(2);
                r_burst  <= BURST_W'(1);
                r_pol    <= 1'b0;
                r_ext_en <= 1'b0;
            end else if (w_sel) begin
                case (cfg_addr)
                    3'd0: r_delay  <= cfg_data;
                    3'd1: r_width  <= cfg_data;
                    3'd2: r_period <= cfg_data;
                    3'd3: r_burst  <= cfg_data[BURST_W-1:0];
                    3'd4: begin
                        r_pol    <= cfg_data[0];
                        r_ext_en <= cfg_data[1];
                    end
                    default: ;
                endcase
            end
        end

        // Clamped live config; only sampled into the shadow on an accepted start
        assign w_per_eff = (r_period < CNT_W'(2)) ? CNT_W'(2) : r_period;
        assign w_wid_eff = (r_width >= w_per_eff) ? (w_per_eff - CNT_W'(1)) : r_width;
        assign w_low_eff = w_per_eff - w_wid_eff;

        assign w_start = sw_trig[gi] | (r_ext_en & w_ext_rise);
        assign w_pol   = (r_state != c_st_idle) ? r_sh_pol : r_pol;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_rem_nxt   = r_rem;
            w_load      = 1'b0;
            w_finish    = 1'b0;
            if (stop[gi]) begin
                w_state_nxt = c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_start) begin
                            w_load    = 1'b1;
                            w_rem_nxt = (r_burst == '0) ? '0 : (r_burst - BURST_W'(1));
                            if (r_delay != '0) begin
                                w_state_nxt = c_st_delay;
                                w_cnt_nxt   = r_delay - CNT_W'(1);
                            end else if (w_wid_eff != '0) begin
                                w_state_nxt = c_st_high;
                                w_cnt_nxt   = w_wid_eff - CNT_W'(1);
                            end else begin
                                w_state_nxt = c_st_low;
                                w_cnt_nxt   = w_low_eff - CNT_W'(1);
                            end
                        end
                    end
                    c_st_delay: begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end else if (r_sh_width != '0) begin
                            w_state_nxt = c_st_high;
                            w_cnt_nxt   = r_sh_width - CNT_W'(1);
                        end else begin
                            w_state_nxt = c_st_low;
                            w_cnt_nxt   = r_sh_low - CNT_W'(1);
                        end
                    end
                    c_st_high: begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end else begin
                            w_state_nxt = c_st_low;
                            w_cnt_nxt   = r_sh_low - CNT_W'(1);
                        end
                    end
                    c_st_low: begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end else if (!r_sh_cont && (r_rem == '0)) begin
                            w_state_nxt = c_st_idle;
                            w_finish    = 1'b1;
                        end else begin
                            if (!r_sh_cont) begin
                                w_rem_nxt = r_rem - BURST_W'(1);
                            end
                            // A zero-width period skips HIGH and spends the whole period in LOW
                            if (r_sh_width != '0) begin
                                w_state_nxt = c_st_high;
                                w_cnt_nxt   = r_sh_width - CNT_W'(1);
                            end else begin
                                w_state_nxt = c_st_low;
                                w_cnt_nxt   = r_sh_low - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = c_st_idle;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= c_st_idle;
                r_cnt       <= '0;
                r_rem       <= '0;
                r_sh_width  <= '0;
                r_sh_low    <= '0;
                r_sh_pol    <= 1'b0;
                r_sh_cont   <= 1'b0;
                r_pulse     <= 1'b0;
                r_done_pend <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_rem   <= w_rem_nxt;
                if (w_load) begin
                    r_sh_width <= w_wid_eff;
                    r_sh_low   <= w_low_eff;
                    r_sh_pol   <= r_pol;
                    r_sh_cont  <= (r_burst == '0);
                end
                r_pulse     <= (r_state == c_st_high) ^ w_pol;
                // done is delayed one stage so it lines up with the registered pulse_out
                r_done_pend <= w_finish;
                r_done      <= r_done_pend;
            end
        end

        assign pulse_out[gi] = r_pulse;
        assign busy[gi]      = (r_state != c_st_idle);
        assign done[gi]      = r_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gen_multi
//  Purpose  : Self-checking bench for pulse_gen_multi: table of burst
//             configurations plus hand-written trigger/stop/reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pulse_gen_multi;

    localparam int N_CH    = 4;
    localparam int CNT_W   = 24;
    localparam int BURST_W = 16;
    localparam int CH_W    = 4;
`ifdef PULSE_GEN_TRIG_SYNC_EN
    localparam int c_ext_lat = 2;
`else
    localparam int c_ext_lat = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [2:0]        cfg_addr;
    logic [CNT_W-1:0]  cfg_data;
    logic              ext_trig;
    logic [N_CH-1:0]   sw_trig;
    logic [N_CH-1:0]   stop;
    logic [N_CH-1:0]   pulse_out;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   done;

    int n_total = 0;
    int n_bad   = 0;
    logic [2:0] sb_q[$];

    typedef struct {
        int ch;
        int d;
        int w;
        int p;
        int b;
        int pol;
        int exp_we;
        int exp_pe;
    } vec_t;

    vec_t vecs[7];

    pulse_gen_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W),
        .CH_W    (CH_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .ext_trig  (ext_trig),
        .sw_trig   (sw_trig),
        .stop      (stop),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cfg_write(input int ch, input int addr, input int data);
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_addr = 3'(addr);
        cfg_data = CNT_W'(data);
        step();
        cfg_wr   = 1'b0;
    endtask

    task automatic cfg_channel(input int ch, input int d, input int w, input int p,
                               input int b, input int ctrl);
        cfg_write(ch, 0, d);
        cfg_write(ch, 1, w);
        cfg_write(ch, 2, p);
        cfg_write(ch, 3, b);
        cfg_write(ch, 4, ctrl);
    endtask

    // Expected {pulse_out, busy, done} u edges after the start edge
    function automatic logic [2:0] expect_at(input int u, input int d, input int we, input int pe,
                                             input int b, input int pol, input int stop_u);
        logic act;
        logic bsy;
        logic dn;
        bsy = (u >= 0) && (u <= d + b * pe - 1);
        dn  = (u == d + b * pe + 1);
        act = 1'b0;
        if (u >= 1 + d) begin
            if (((u - 1 - d) / pe) < b && ((u - 1 - d) % pe) < we) act = 1'b1;
        end
        if (stop_u >= 0 && u >= stop_u) begin
            bsy = 1'b0;
            dn  = 1'b0;
            if (u > stop_u) act = 1'b0;
        end
        return {act ^ (pol != 0), bsy, dn};
    endfunction

    task automatic run_burst(input string name, input int ch, input int d, input int we,
                             input int pe, input int b, input int pol, input bit use_ext,
                             input int mid_t, input int mid_p, input int stop_u, input int t_end);
        int lat;
        int last;
        logic [2:0] got;
        logic [2:0] want;
        lat  = use_ext ? c_ext_lat : 0;
        last = (t_end >= 0) ? t_end : lat + d + b * pe + 3;
        for (int t = 0; t <= last; t++) begin
            if (t == 0) begin
                if (use_ext) ext_trig = 1'b1;
                else         sw_trig[ch] = 1'b1;
            end
            if (mid_t >= 0 && t == mid_t) begin
                cfg_wr   = 1'b1;
                cfg_ch   = CH_W'(ch);
                cfg_addr = 3'd2;
                cfg_data = CNT_W'(mid_p);
            end
            if (stop_u >= 0 && (t - lat) == stop_u) stop[ch] = 1'b1;
            sb_q.push_back(expect_at(t - lat, d, we, pe, b, pol, stop_u));
            step();
            sw_trig  = '0;
            ext_trig = 1'b0;
            cfg_wr   = 1'b0;
            stop     = '0;
            got = {pulse_out[ch], busy[ch], done[ch]};
            if (sb_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL %s scoreboard empty at t=%0d", name, t);
            end else begin
                want = sb_q.pop_front();
                check($sformatf("%s t=%0d {pulse,busy,done}", name, t), 32'(got), 32'(want));
            end
        end
    endtask

    initial begin
        int u;
        // ch, delay, width, period, burst, pol, clamped width, clamped period
        vecs[0] = '{0, 3,  2, 5, 3, 0, 2, 5};
        vecs[1] = '{1, 0,  1, 2, 2, 0, 1, 2};
        vecs[2] = '{2, 1, 10, 4, 2, 1, 3, 4};
        vecs[3] = '{3, 0,  0, 3, 2, 0, 0, 3};
        vecs[4] = '{0, 2,  3, 0, 1, 0, 1, 2};
        vecs[5] = '{1, 4,  4, 4, 1, 1, 3, 4};
        vecs[6] = '{2, 0,  5, 7, 3, 0, 5, 7};

        rst_n    = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = '0;
        cfg_addr = '0;
        cfg_data = '0;
        ext_trig = 1'b0;
        sw_trig  = '0;
        stop     = '0;
        step();
        step();
        check("reset pulse_out", 32'(pulse_out), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        rst_n = 1'b1;
        step();

        // Reset defaults: delay 0, width 1, period 2, burst 1
        run_burst("default", 0, 0, 1, 2, 1, 0, 1'b0, -1, 0, -1, -1);

        for (int i = 0; i < 7; i++) begin
            cfg_channel(vecs[i].ch, vecs[i].d, vecs[i].w, vecs[i].p, vecs[i].b, vecs[i].pol);
            run_burst($sformatf("vec%0d", i), vecs[i].ch, vecs[i].d, vecs[i].exp_we,
                      vecs[i].exp_pe, vecs[i].b, vecs[i].pol, 1'b0, -1, 0, -1, -1);
        end

        // Out-of-range register and channel writes leave ch0 untouched
        cfg_channel(0, 0, 1, 3, 1, 0);
        cfg_write(0, 5, 7);
        cfg_write(0, 6, 7);
        cfg_write(0, 7, 3);
        cfg_write(7, 2, 9);
        run_burst("badaddr", 0, 0, 1, 3, 1, 0, 1'b0, -1, 0, -1, -1);

        // Continuous ch1 via ext_trig, aborted by stop: no done
        cfg_channel(1, 0, 1, 4, 0, 2);
        run_burst("cont_stop", 1, 0, 1, 4, 1000, 0, 1'b1, -1, 0, 13, c_ext_lat + 18);

        // Shared ext_trig: ch0/ch2 enabled, ch1/ch3 not; retrigger while busy ignored
        cfg_channel(0, 0, 1, 6, 1, 2);
        cfg_channel(2, 0, 1, 6, 1, 2);
        cfg_write(1, 4, 0);
        cfg_write(3, 4, 0);
        for (int t = 0; t <= c_ext_lat + 9; t++) begin
            u = t - c_ext_lat;
            if (t == 0) ext_trig = 1'b1;
            if (u == 2) sw_trig = 4'b0101;
            step();
            ext_trig = 1'b0;
            sw_trig  = '0;
            check($sformatf("ext busy t=%0d", t), 32'(busy),
                  (u >= 0 && u <= 5) ? 32'h5 : 32'h0);
            check($sformatf("ext done t=%0d", t), 32'(done),
                  (u == 7) ? 32'h5 : 32'h0);
        end

        // Mid-burst period rewrite on ch3 keeps the shadow period
        cfg_channel(3, 0, 2, 6, 2, 0);
        run_burst("mid_old", 3, 0, 2, 6, 2, 0, 1'b0, 3, 20, -1, -1);
        run_burst("mid_new", 3, 0, 2, 20, 2, 0, 1'b0, -1, 0, -1, -1);

        // Stop and start in the same cycle: stop wins
        sw_trig[3] = 1'b1;
        stop[3]    = 1'b1;
        step();
        sw_trig = '0;
        stop    = '0;
        check("stop_wins busy", 32'(busy[3]), 32'h0);
        step();
        check("stop_wins busy2", 32'(busy[3]), 32'h0);
        check("stop_wins pulse", 32'(pulse_out[3]), 32'h0);

        // Asynchronous reset mid-burst, then defaults restored
        cfg_channel(0, 0, 2, 10, 5, 0);
        cfg_write(2, 4, 1);
        sw_trig[0] = 1'b1;
        step();
        sw_trig = '0;
        repeat (4) step();
        check("pre_rst busy", 32'(busy[0]), 32'h1);
        check("pre_rst idle pol ch2", 32'(pulse_out[2]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst pulse_out", 32'(pulse_out), 32'h0);
        check("async_rst busy", 32'(busy), 32'h0);
        check("async_rst done", 32'(done), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst done", 32'(done), 32'h0);
        run_burst("post_rst_dflt", 0, 0, 1, 2, 1, 0, 1'b0, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
